// File: rtl/mac_result_requant_drain.sv
// Requantizes a finished MAC accumulator word into 1/2/4 signed 8-bit lanes
// and streams them out, one lane per beat, through a small valid/ready FIFO.
module mac_result_requant_drain #(
  parameter int ACC_W = 56,
  parameter int OUT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             acc_valid,
  output logic             acc_ready,
  input  logic [ACC_W-1:0] acc_data,
  input  logic [1:0]       prec_level,
  input  logic [5:0]       shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_lane,
  output logic             out_last,
  output logic             out_sat,
  output logic             err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = OUT_W + 4;
  localparam logic signed [56:0] SAT_MAX = 57'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [56:0] SAT_MIN = 57'(-(2 ** (OUT_W - 1)));

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t state, state_nxt;
  logic              alive;
  logic              accept, push, pop, full;
  logic [ACC_W-1:0]  acc_q;
  logic [1:0]        prec_q;
  logic [5:0]        sh_q;
  logic [1:0]        cnt;
  logic              lane_last, q_sat;
  logic [OUT_W-1:0]  q_data;
  logic signed [56:0] x, rnd, sum, v;
  logic [27:0]       half;
  logic [13:0]       quarter;

  logic [EW-1:0]     mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [EW-1:0]     head;

  // alive keeps acc_ready low during reset and until the first edge after release
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      alive <= 1'b0;
    end else begin
      state <= state_nxt;
      alive <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_ready = 1'b0;
    accept    = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE: begin
        acc_ready = alive;
        accept    = acc_valid & alive;
        if (accept && prec_level != 2'b11) state_nxt = DRAIN;
      end
      DRAIN: begin
        push = ~full;
        if (push && lane_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q  <= '0;
      prec_q <= '0;
      sh_q   <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      err <= accept && (prec_level == 2'b11);
      if (accept) begin
        acc_q  <= acc_data;
        prec_q <= prec_level;
        sh_q   <= (shamt > 6'd55) ? 6'd55 : shamt;
        cnt    <= '0;
      end else if (push) begin
        cnt <= cnt + 2'd1;
      end
    end
  end

  // Lane select, sign-extend to 57 bits, round-half-up shift, saturate.
  always_comb begin
    half    = cnt[0] ? acc_q[55:28] : acc_q[27:0];
    quarter = acc_q[13:0];
    case (cnt)
      2'd1:    quarter = acc_q[27:14];
      2'd2:    quarter = acc_q[41:28];
      2'd3:    quarter = acc_q[55:42];
      default: quarter = acc_q[13:0];
    endcase
    case (prec_q)
      2'b00: begin
        x         = {acc_q[55], acc_q[55:0]};
        lane_last = 1'b1;
      end
      2'b01: begin
        x         = {{29{half[27]}}, half};
        lane_last = (cnt == 2'd1);
      end
      default: begin
        x         = {{43{quarter[13]}}, quarter};
        lane_last = (cnt == 2'd3);
      end
    endcase
    rnd = (sh_q == '0) ? '0 : (57'(1) << (sh_q - 6'd1));
    sum = x + rnd;
    v   = sum >>> sh_q;
    if (v > SAT_MAX) begin
      q_data = SAT_MAX[OUT_W-1:0];
      q_sat  = 1'b1;
    end else if (v < SAT_MIN) begin
      q_data = SAT_MIN[OUT_W-1:0];
      q_sat  = 1'b1;
    end else begin
      q_data = v[OUT_W-1:0];
      q_sat  = 1'b0;
    end
  end

  assign full = (count == CW'(DEPTH));
  assign pop  = (count != '0) & out_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {q_data, cnt, lane_last, q_sat};
  end

  // Head fields are forced to zero while empty so reset/empty outputs read 0.
  assign head      = mem[rd_ptr];
  assign out_valid = (count != '0);
  assign {out_data, out_lane, out_last, out_sat} = out_valid ? head : '0;

endmodule
